alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the 32-bit add/subtract unit in the ALU.
- Registers the ALU result and destination register index into a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Maintains the architectural flag register (S, Z, C, V), loaded from the adder flags.
- Evaluates a 4-bit branch condition code against the stored flags.

---
 rtl/alu_result_stage_pkg.sv | 40 ++++
 rtl/alu_result_stage_cond_eval.sv | 53 +++++
 rtl/alu_result_stage.sv | 141 ++++++++++++++
 tb/tb_alu_result_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_stage_pkg
// Shared ALU definitions used by the result stage and by the branch unit:
//   - branch condition-code encodings COND_EQ .. COND_NV
//   - bit positions of the packed {S,Z,C,V} flag word
//   - state encoding of the two-entry result skid buffer
// No ports; import with alu_result_stage_pkg::*.
// ---------------------------------------------------------------------------
package alu_result_stage_pkg;

    // Branch condition codes, evaluated against the architectural flags.
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the packed flag word {S,Z,C,V}.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Occupancy states of the result skid buffer.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch-condition evaluator, shared with the branch
// unit.
// Ports:
//   flags_i      in  4  architectural flags, packed {S,Z,C,V}
//   cond_i       in  4  condition code (COND_EQ .. COND_NV)
//   cond_true_o  out 1  1 when the condition holds for flags_i
// ---------------------------------------------------------------------------
module cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       cond_true_o
);

    logic flagS;
    logic flagZ;
    logic flagC;
    logic flagV;

    assign flagS = flags_i[FLAG_S];
    assign flagZ = flags_i[FLAG_Z];
    assign flagC = flags_i[FLAG_C];
    assign flagV = flags_i[FLAG_V];

    // Decode the condition code into a single truth value. The unsigned
    // comparisons (HI/LS) treat C as "no borrow", the signed ones (GE..LE)
    // compare the sign against the overflow flag.
    always_comb begin
        cond_true_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_true_o = flagZ;
            COND_NE: cond_true_o = !flagZ;
            COND_CS: cond_true_o = flagC;
            COND_CC: cond_true_o = !flagC;
            COND_MI: cond_true_o = flagS;
            COND_PL: cond_true_o = !flagS;
            COND_VS: cond_true_o = flagV;
            COND_VC: cond_true_o = !flagV;
            COND_HI: cond_true_o = flagC && !flagZ;
            COND_LS: cond_true_o = !flagC || flagZ;
            COND_GE: cond_true_o = (flagS == flagV);
            COND_LT: cond_true_o = (flagS != flagV);
            COND_GT: cond_true_o = !flagZ && (flagS == flagV);
            COND_LE: cond_true_o = flagZ || (flagS != flagV);
            COND_AL: cond_true_o = 1'b1;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Result stage behind the 32-bit add/subtract unit. Holds up to two results
// (head + skid) toward writeback with a valid/ready handshake, keeps the
// architectural {S,Z,C,V} flag register and evaluates a branch condition
// against it.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready is a pure state decode)
//   in_result, in_rd      result word and destination index from the adder
//   in_zflag, in_carry,
//   in_sign, in_overflow  adder flags
//   in_flag_we            this result updates the flag register
//   out_valid / out_ready downstream (writeback) handshake
//   out_result, out_rd    head entry
//   flags                 architectural flags {S,Z,C,V}
//   cond / cond_true      condition code and its combinational evaluation
// ---------------------------------------------------------------------------
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_zflag,
    input  logic              in_carry,
    input  logic              in_sign,
    input  logic              in_overflow,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    logic [1:0]        state_q,      state_d;
    logic [DATA_W-1:0] headResult_q, headResult_d;
    logic [RD_W-1:0]   headRd_q,     headRd_d;
    logic [DATA_W-1:0] skidResult_q, skidResult_d;
    logic [RD_W-1:0]   skidRd_q,     skidRd_d;
    logic [3:0]        flags_q,      flags_d;

    logic push;
    logic pop;

    // Both handshake outputs decode the state register only, so in_ready has
    // no combinational path from out_ready.
    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = headResult_q;
    assign out_rd     = headRd_q;
    assign flags      = flags_q;

    // Skid-buffer next state. The head register always drives the outputs;
    // the skid register only catches the second entry while the head stalls.
    // Registers change only on a handshake so the outputs hold while
    // stalled and while empty.
    always_comb begin
        state_d      = state_q;
        headResult_d = headResult_q;
        headRd_d     = headRd_q;
        skidResult_d = skidResult_q;
        skidRd_d     = skidRd_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d      = ST_ONE;
                    headResult_d = in_result;
                    headRd_d     = in_rd;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_d      = ST_FULL;
                    skidResult_d = in_result;
                    skidRd_d     = in_rd;
                end else if (pop && !push) begin
                    state_d      = ST_EMPTY;
                end else if (push && pop) begin
                    headResult_d = in_result;
                    headRd_d     = in_rd;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d      = ST_ONE;
                    headResult_d = skidResult_q;
                    headRd_d     = skidRd_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Flags load on an accepted flag-writing result, regardless of whether
    // writeback is currently stalled.
    always_comb begin
        flags_d = flags_q;
        if (push && in_flag_we) begin
            flags_d = {in_sign, in_zflag, in_carry, in_overflow};
        end
    end

    // State and data registers. Reset discards any buffered entries and
    // blocks an input presented in the same cycle from being accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            headResult_q <= '0;
            headRd_q     <= '0;
            skidResult_q <= '0;
            skidRd_q     <= '0;
            flags_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            headResult_q <= headResult_d;
            headRd_q     <= headRd_d;
            skidResult_q <= skidResult_d;
            skidRd_q     <= skidRd_d;
            flags_q      <= flags_d;
        end
    end

    cond_eval u_cond_eval (
        .flags_i     (flags_q),
        .cond_i      (cond),
        .cond_true_o (cond_true)
    );

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Scoreboard bench for alu_result_stage: the stimulus side pushes every
// accepted result into an expected queue, and an independent monitor compares
// the DUT head entry, handshake signals, flags and condition result against
// a behavioural model every falling edge.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inResult;
    logic [4:0]  inRd;
    logic        inZflag;
    logic        inCarry;
    logic        inSign;
    logic        inOverflow;
    logic        inFlagWe;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic [4:0]  outRd;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic        condTrue;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
    } entry_t;

    entry_t     expQ[$];
    int         occ;
    logic [3:0] flagsModel;
    bit         pushModel;
    bit         popModel;
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .DATA_W (32),
        .RD_W   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_result   (inResult),
        .in_rd       (inRd),
        .in_zflag    (inZflag),
        .in_carry    (inCarry),
        .in_sign     (inSign),
        .in_overflow (inOverflow),
        .in_flag_we  (inFlagWe),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_result  (outResult),
        .out_rd      (outRd),
        .flags       (flags),
        .cond        (cond),
        .cond_true   (condTrue)
    );

    // Reference condition table, written directly from the flag meanings.
    function automatic logic refCond(input logic [3:0] f, input logic [3:0] c);
        logic s;
        logic z;
        logic cy;
        logic v;
        s  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return s;
            4'h5: return !s;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return s == v;
            4'hB: return s != v;
            4'hC: return !z && (s == v);
            4'hD: return z || (s != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and hold them
    // through the next rising edge. f is packed {S,Z,C,V}.
    task automatic applyStimulus(input logic v, input logic [31:0] r,
                                 input logic [4:0] rd, input logic [3:0] f,
                                 input logic we, input logic ordy,
                                 input logic [3:0] c);
        inValid    = v;
        inResult   = r;
        inRd       = rd;
        inSign     = f[3];
        inZflag    = f[2];
        inCarry    = f[1];
        inOverflow = f[0];
        inFlagWe   = we;
        outReady   = ordy;
        cond       = c;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a FIFO of capacity two plus a flag register. An
    // input is taken when fewer than two entries are held; an entry leaves
    // when one is held and writeback is ready.
    initial begin
        occ        = 0;
        flagsModel = 4'b0000;
        forever begin
            @(posedge clk);
            if (reset) begin
                occ        = 0;
                flagsModel = 4'b0000;
                expQ.delete();
            end else begin
                pushModel = inValid && (occ < 2);
                popModel  = (occ > 0) && outReady;
                if (pushModel) begin
                    expQ.push_back('{inResult, inRd});
                    if (inFlagWe) flagsModel = {inSign, inZflag, inCarry, inOverflow};
                end
                occ = occ + int'(pushModel) - int'(popModel);
            end
        end
    end

    // Monitor: compares the presented head entry with the scoreboard and
    // retires it when writeback takes it.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("in_ready", 64'(inReady), 64'(occ < 2));
            checkOutput("out_valid", 64'(outValid), 64'(occ > 0));
            checkOutput("flags", 64'(flags), 64'(flagsModel));
            checkOutput("cond_true", 64'(condTrue), 64'(refCond(flagsModel, cond)));
            if (outValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got result %0h, expected no entry", outResult);
                end else begin
                    checkOutput("out_result", 64'(outResult), 64'(expQ[0].result));
                    checkOutput("out_rd", 64'(outRd), 64'(expQ[0].rd));
                    if (outReady) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        inValid    = 1'b0;
        inResult   = '0;
        inRd       = '0;
        inZflag    = 1'b0;
        inCarry    = 1'b0;
        inSign     = 1'b0;
        inOverflow = 1'b0;
        inFlagWe   = 1'b0;
        outReady   = 1'b0;
        cond       = COND_EQ;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 5-3: result 2, carry (no borrow) set, into r7.
        applyStimulus(1'b1, 32'h2, 5'd7, 4'b0010, 1'b1, 1'b1, COND_HI);
        inValid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t1_result", 64'(outResult), 64'h2);
        checkOutput("t1_rd", 64'(outRd), 64'd7);
        checkOutput("t1_flags", 64'(flags), 64'b0010);
        checkOutput("t1_hi", 64'(condTrue), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: A and B fill the buffer, C waits upstream.
        applyStimulus(1'b1, 32'h11, 5'd1, 4'b0000, 1'b0, 1'b0, COND_AL);
        applyStimulus(1'b1, 32'h22, 5'd2, 4'b0000, 1'b0, 1'b0, COND_AL);
        applyStimulus(1'b1, 32'h33, 5'd3, 4'b0000, 1'b0, 1'b0, COND_AL);
        checkOutput("t2_full_in_ready", 64'(inReady), 64'd0);
        applyStimulus(1'b1, 32'h33, 5'd3, 4'b0000, 1'b0, 1'b1, COND_AL);
        applyStimulus(1'b1, 32'h33, 5'd3, 4'b0000, 1'b0, 1'b1, COND_AL);
        applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);
        applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);

        // Steady stream at full throughput.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, $urandom, 5'(i + 16), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)));
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);

        // Flag write followed by a non-writing result.
        applyStimulus(1'b1, 32'h8000_0000, 5'd9, 4'b1001, 1'b1, 1'b1, COND_AL);
        applyStimulus(1'b1, 32'h0, 5'd10, 4'b0100, 1'b0, 1'b1, COND_AL);
        inValid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t4_flags", 64'(flags), 64'b1001);
        cond = COND_GE;
        #1;
        checkOutput("t4_ge", 64'(condTrue), 64'd1);
        cond = COND_LT;
        #1;
        checkOutput("t4_lt", 64'(condTrue), 64'd0);
        cond = COND_EQ;
        #1;
        checkOutput("t4_eq", 64'(condTrue), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);

        // Reset while full and stalled, with an input offered in that cycle.
        applyStimulus(1'b1, 32'hAA, 5'd11, 4'b1111, 1'b1, 1'b0, COND_AL);
        applyStimulus(1'b1, 32'hBB, 5'd12, 4'b0110, 1'b1, 1'b0, COND_AL);
        reset = 1'b1;
        applyStimulus(1'b1, 32'hCC, 5'd13, 4'b1010, 1'b1, 1'b0, COND_AL);
        reset   = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t5_out_valid", 64'(outValid), 64'd0);
        checkOutput("t5_in_ready", 64'(inReady), 64'd1);
        checkOutput("t5_flags", 64'(flags), 64'd0);
        checkOutput("t5_result", 64'(outResult), 64'd0);
        checkOutput("t5_rd", 64'(outRd), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'hDD, 5'd14, 4'b0000, 1'b0, 1'b1, COND_AL);
        applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);

        // Condition sweep over every flag value.
        for (int f = 0; f < 16; f++) begin
            applyStimulus(1'b1, 32'(f), 5'(f), 4'(f), 1'b1, 1'b1, COND_AL);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, 4'(c));
            end
        end

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)));
        end

        // Drain and confirm every accepted entry came out.
        repeat (4) applyStimulus(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, COND_AL);
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
